ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs.
- Resolves operand forwarding and computes the ALU result. Multiply runs on an iterative shift-add unit.
- Owns the EX/MEM pipeline register, which feeds the MEM stage.
- Asserts a stall to freeze PC, IF/ID and ID/EX while a multiply is in flight.

Parameters:
- LEN_DATA, 32, datapath width
- LEN_INST_REG, 5, register-index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_ALUSrc  in  1  1: operand B = i_imm
- i_ALUop  in  3  ALU operation (encoding in Behaviour)
- i_RegDst  in  1  1: destination = i_rd, 0: i_rt
- i_MemRead, i_MemWrite, i_PCSrc, i_RegWrite, i_MemToReg  in  1 each  MEM/WB control bits from ID/EX
- i_data1, i_data2  in  LEN_DATA  register-file read data (rs, rt)
- i_imm  in  LEN_DATA  sign-extended immediate
- i_rs, i_rt, i_rd  in  LEN_INST_REG  register indices
- i_flush  in  1  squash the instruction currently in EX
- i_wb_RegWrite  in  1  WB stage write enable
- i_wb_rd  in  LEN_INST_REG  WB destination
- i_wb_data  in  LEN_DATA  WB write data
- o_stall  out  1  hold PC, IF/ID and ID/EX
- o_ALUres  out  LEN_DATA  registered ALU result / memory address
- o_wdata  out  LEN_DATA  registered store data (forwarded rt)
- o_wreg  out  LEN_INST_REG  registered destination index
- o_zero  out  1  registered (ALU result == 0)
- o_MemRead, o_MemWrite, o_PCSrc, o_RegWrite, o_MemToReg  out  1 each  registered control bits

Behaviour:
- Reset (rst=1 at posedge): every registered output is 0; FSM goes to IDLE, counter 0. The reset value of o_stall is 0.
- ALUop encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 1/0)
  - 101 mul (low LEN_DATA bits of the product), 110 nor, 111 pass B
  - Add/sub wrap modulo 2^LEN_DATA; no overflow trap.
- Forwarding, per source operand (rs→A, rt→B_reg):
  - If o_RegWrite && o_wreg!=0 && o_wreg==index, use o_ALUres.
  - Else if i_wb_RegWrite && i_wb_rd!=0 && i_wb_rd==index, use i_wb_data.
  - Else use the register-file data.
  - EX/MEM has priority over WB. Register 0 is never forwarded.
- Operand B = i_ALUSrc ? i_imm : B_reg. o_wdata captures B_reg, never i_imm.
- Single-cycle ops (not 101), no stall:
  - The EX/MEM register captures the result, control bits, B_reg and the destination at the next posedge.
  - 1-cycle latency.
- Multiply FSM has states IDLE, BUSY and DONE.
  - IDLE with i_ALUop==101 and !i_flush:
    - o_stall=1 combinationally.
    - Latch forwarded A and B into multiplicand/multiplier, clear the accumulator, counter=0.
    - Latch destination and control bits.
    - Go to BUSY. The EX/MEM register loads a bubble (all control bits 0).
  - BUSY:
    - o_stall=1. One shift-add iteration per cycle; counter +1.
    - When counter reaches LEN_DATA-1, go to DONE.
    - The EX/MEM register loads a bubble each cycle.
  - DONE:
    - o_stall=0. The EX/MEM register captures the accumulator plus the latched control, destination and B.
    - Go to IDLE.
  - Total: o_stall high for LEN_DATA+1 consecutive cycles. The product is visible LEN_DATA+2 cycles after the mul is presented.
- Operands are latched at mul start because the forwarding sources drain to bubbles during the stall.
- i_flush:
  - In IDLE or DONE, the EX/MEM register loads a bubble; data fields may be don't-care, control bits must be 0.
  - In BUSY, abort the multiply: go to IDLE, bubble, o_stall=0 that cycle.
  - In IDLE with a mul presented, no multiply starts.
- rst mid-multiply: immediate return to IDLE, outputs 0, no product emitted.
- A mul in ID/EX directly after a completed mul (DONE→IDLE) starts normally on the next cycle.
- o_zero is derived from the same value written to o_ALUres.

Decomposition:
- Shared package (existing defs include) holds:
  - LEN_DATA and LEN_INST_REG.
  - ALUop codes ALU_ADD … ALU_PASSB.
  - FSM state encodings.
- One sub-module: ex_mul_iter (start, abort, a, b → busy, done, product). It holds the shift-add datapath and counter.
- Forwarding, ALU and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset: drive rst with random inputs → all outputs 0, o_stall 0.
- add $3,$1,$2 with data1=5, data2=7, RegDst=1, rd=3, RegWrite=1 → next cycle o_ALUres=12, o_wreg=3, o_RegWrite=1, o_zero=0.
- Back-to-back dependency: add $3 → 12, then sub $4,$3,$2 (i_data1 stale=0, data2=7) → o_ALUres=5 via EX/MEM forward. Repeat with WB-only match (i_wb_rd=3, i_wb_data=20) → 13. Repeat with both sources matching → EX/MEM wins. Repeat with rd=0 → no forward.
- mul 6×7, then mul 0xFFFFFFFF×2:
  - o_stall high exactly 33 cycles, bubbles in EX/MEM meanwhile.
  - Then o_ALUres=42, then 0xFFFFFFFE; o_RegWrite high only in the result cycle.
- i_flush asserted at cycle 10 of a mul → o_stall drops that cycle, no result ever written, FSM accepts a new add next cycle.
- rst asserted mid-mul (cycle 5) → outputs 0, o_stall 0. A following slt with A=-1, B=1 gives o_ALUres=1; sw with ALUSrc=1, imm=8 gives o_ALUres=base+8 and o_wdata=forwarded rt.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes,
// multiply FSM encoding, the MEM/WB control bundle and the ALU function.
package ex_stage_pkg;

  localparam int LEN_DATA     = 32;
  localparam int LEN_INST_REG = 5;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;
  localparam logic [2:0] ALU_NOR   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Control bits travelling from ID/EX into EX/MEM
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic pc_src;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  // Single-cycle ALU; multiply is produced by the iterative unit instead
  function automatic logic [LEN_DATA-1:0] alu_compute(
    input logic [2:0]          op,
    input logic [LEN_DATA-1:0] a,
    input logic [LEN_DATA-1:0] b
  );
    logic [LEN_DATA-1:0] r;
    r = {LEN_DATA{1'b0}};
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_SLT:   r = {{(LEN_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_MUL:   r = {LEN_DATA{1'b0}};
      ALU_NOR:   r = ~(a | b);
      ALU_PASSB: r = b;
      default:   r = {LEN_DATA{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle,
// WIDTH iterations, low WIDTH bits of the product kept.
module ex_mul_iter
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = LEN_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t       state;
  mul_state_t       next_state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: last iteration runs while count == WIDTH-1
  always_comb begin
    next_state = state;
    case (state)
      MUL_IDLE: begin
        if (start) next_state = MUL_BUSY;
        else       next_state = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (abort)                         next_state = MUL_IDLE;
        else if (count == CW'(WIDTH - 1))  next_state = MUL_DONE;
        else                               next_state = MUL_BUSY;
      end
      MUL_DONE: next_state = MUL_IDLE;
      default:  next_state = MUL_IDLE;
    endcase
  end

  // FSM status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      MUL_BUSY: busy = 1'b1;
      MUL_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Shift-add datapath and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= {WIDTH{1'b0}};
      mplier <= {WIDTH{1'b0}};
      acc    <= {WIDTH{1'b0}};
      count  <= {CW{1'b0}};
    end else if (state == MUL_IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= {WIDTH{1'b0}};
      count  <= {CW{1'b0}};
    end else if (state == MUL_BUSY && !abort) begin
      if (mplier[0]) acc <= acc + mcand;
      else           acc <= acc;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count + CW'(1);
    end else begin
      mcand  <= mcand;
      mplier <= mplier;
      acc    <= acc;
      count  <= count;
    end
  end

  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, iterative multiply control
// and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ALUSrc,
  input  logic [2:0]              i_ALUop,
  input  logic                    i_RegDst,
  input  logic                    i_MemRead,
  input  logic                    i_MemWrite,
  input  logic                    i_PCSrc,
  input  logic                    i_RegWrite,
  input  logic                    i_MemToReg,
  input  logic [LEN_DATA-1:0]     i_data1,
  input  logic [LEN_DATA-1:0]     i_data2,
  input  logic [LEN_DATA-1:0]     i_imm,
  input  logic [LEN_INST_REG-1:0] i_rs,
  input  logic [LEN_INST_REG-1:0] i_rt,
  input  logic [LEN_INST_REG-1:0] i_rd,
  input  logic                    i_flush,
  input  logic                    i_wb_RegWrite,
  input  logic [LEN_INST_REG-1:0] i_wb_rd,
  input  logic [LEN_DATA-1:0]     i_wb_data,
  output logic                    o_stall,
  output logic [LEN_DATA-1:0]     o_ALUres,
  output logic [LEN_DATA-1:0]     o_wdata,
  output logic [LEN_INST_REG-1:0] o_wreg,
  output logic                    o_zero,
  output logic                    o_MemRead,
  output logic                    o_MemWrite,
  output logic                    o_PCSrc,
  output logic                    o_RegWrite,
  output logic                    o_MemToReg
);

  logic [LEN_DATA-1:0]     op_a;
  logic [LEN_DATA-1:0]     b_reg;
  logic [LEN_DATA-1:0]     op_b;
  logic [LEN_INST_REG-1:0] dest;
  ctrl_t                   ctrl_in;

  logic                    mul_start;
  logic                    mul_busy;
  logic                    mul_done;
  logic [LEN_DATA-1:0]     mul_product;

  ctrl_t                   mul_ctrl;
  logic [LEN_INST_REG-1:0] mul_dest;
  logic [LEN_DATA-1:0]     mul_wdata;

  logic [LEN_DATA-1:0]     nx_res;
  logic [LEN_DATA-1:0]     nx_wdata;
  logic [LEN_INST_REG-1:0] nx_wreg;
  ctrl_t                   nx_ctrl;

  // EX/MEM has priority over WB; register 0 is never forwarded
  function automatic logic [LEN_DATA-1:0] forward(
    input logic [LEN_INST_REG-1:0] idx,
    input logic [LEN_DATA-1:0]     rf_data,
    input logic                    mem_we,
    input logic [LEN_INST_REG-1:0] mem_rd,
    input logic [LEN_DATA-1:0]     mem_data,
    input logic                    wb_we,
    input logic [LEN_INST_REG-1:0] wb_rd,
    input logic [LEN_DATA-1:0]     wb_data
  );
    logic [LEN_DATA-1:0] v;
    if (mem_we && mem_rd != {LEN_INST_REG{1'b0}} && mem_rd == idx) begin
      v = mem_data;
    end else if (wb_we && wb_rd != {LEN_INST_REG{1'b0}} && wb_rd == idx) begin
      v = wb_data;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  // Operand selection with forwarding
  always_comb begin
    op_a    = forward(i_rs, i_data1, o_RegWrite, o_wreg, o_ALUres,
                      i_wb_RegWrite, i_wb_rd, i_wb_data);
    b_reg   = forward(i_rt, i_data2, o_RegWrite, o_wreg, o_ALUres,
                      i_wb_RegWrite, i_wb_rd, i_wb_data);
    op_b    = i_ALUSrc ? i_imm : b_reg;
    dest    = i_RegDst ? i_rd : i_rt;
    ctrl_in = '{mem_read: i_MemRead, mem_write: i_MemWrite, pc_src: i_PCSrc,
                reg_write: i_RegWrite, mem_to_reg: i_MemToReg};
  end

  assign mul_start = !rst && !mul_busy && !mul_done && (i_ALUop == ALU_MUL) && !i_flush;
  assign o_stall   = !rst && (mul_start || (mul_busy && !i_flush));

  ex_mul_iter #(.WIDTH(LEN_DATA)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (i_flush),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Hold the multiply's destination, control and store data while it iterates,
  // since the forwarding sources drain during the stall
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_ctrl  <= '0;
      mul_dest  <= {LEN_INST_REG{1'b0}};
      mul_wdata <= {LEN_DATA{1'b0}};
    end else if (mul_start) begin
      mul_ctrl  <= ctrl_in;
      mul_dest  <= dest;
      mul_wdata <= b_reg;
    end else begin
      mul_ctrl  <= mul_ctrl;
      mul_dest  <= mul_dest;
      mul_wdata <= mul_wdata;
    end
  end

  // Next EX/MEM contents: bubble, multiply result, or single-cycle result
  always_comb begin
    nx_res   = {LEN_DATA{1'b0}};
    nx_wdata = {LEN_DATA{1'b0}};
    nx_wreg  = {LEN_INST_REG{1'b0}};
    nx_ctrl  = '0;
    if (i_flush) begin
      nx_ctrl = '0;
    end else if (mul_done) begin
      nx_res   = mul_product;
      nx_wdata = mul_wdata;
      nx_wreg  = mul_dest;
      nx_ctrl  = mul_ctrl;
    end else if (mul_start || mul_busy) begin
      nx_ctrl = '0;
    end else begin
      nx_res   = alu_compute(i_ALUop, op_a, op_b);
      nx_wdata = b_reg;
      nx_wreg  = dest;
      nx_ctrl  = ctrl_in;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ALUres   <= {LEN_DATA{1'b0}};
      o_wdata    <= {LEN_DATA{1'b0}};
      o_wreg     <= {LEN_INST_REG{1'b0}};
      o_zero     <= 1'b0;
      o_MemRead  <= 1'b0;
      o_MemWrite <= 1'b0;
      o_PCSrc    <= 1'b0;
      o_RegWrite <= 1'b0;
      o_MemToReg <= 1'b0;
    end else begin
      o_ALUres   <= nx_res;
      o_wdata    <= nx_wdata;
      o_wreg     <= nx_wreg;
      o_zero     <= (nx_res == {LEN_DATA{1'b0}});
      o_MemRead  <= nx_ctrl.mem_read;
      o_MemWrite <= nx_ctrl.mem_write;
      o_PCSrc    <= nx_ctrl.pc_src;
      o_RegWrite <= nx_ctrl.reg_write;
      o_MemToReg <= nx_ctrl.mem_to_reg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ALUSrc, i_RegDst, i_MemRead, i_MemWrite, i_PCSrc, i_RegWrite, i_MemToReg;
  logic [2:0]  i_ALUop;
  logic [31:0] i_data1, i_data2, i_imm, i_wb_data;
  logic [4:0]  i_rs, i_rt, i_rd, i_wb_rd;
  logic        i_flush, i_wb_RegWrite;
  logic        o_stall, o_zero, o_MemRead, o_MemWrite, o_PCSrc, o_RegWrite, o_MemToReg;
  logic [31:0] o_ALUres, o_wdata;
  logic [4:0]  o_wreg;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .i_ALUSrc(i_ALUSrc), .i_ALUop(i_ALUop), .i_RegDst(i_RegDst),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_PCSrc(i_PCSrc),
    .i_RegWrite(i_RegWrite), .i_MemToReg(i_MemToReg), .i_data1(i_data1), .i_data2(i_data2),
    .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_flush(i_flush),
    .i_wb_RegWrite(i_wb_RegWrite), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_stall(o_stall), .o_ALUres(o_ALUres), .o_wdata(o_wdata), .o_wreg(o_wreg),
    .o_zero(o_zero), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_PCSrc(o_PCSrc),
    .o_RegWrite(o_RegWrite), .o_MemToReg(o_MemToReg)
  );

  int checks   = 0;
  int failures = 0;

  // Model of the EX/MEM register as it should look after the last edge
  logic [31:0] m_res, m_wd;
  logic [4:0]  m_reg, m_ctl;   // m_ctl = {MemRead, MemWrite, PCSrc, RegWrite, MemToReg}
  logic        m_zero, m_bub;
  // Model of an outstanding multiply: age counts cycles since it was accepted
  logic        pend = 1'b0;
  int          age  = 0;
  logic [31:0] p_prod, p_b;
  logic [4:0]  p_dest, p_ctl;
  logic        seen_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (m_ctl[1] && m_reg != 5'd0 && m_reg == idx) return m_res;
    if (i_wb_RegWrite && i_wb_rd != 5'd0 && i_wb_rd == idx) return i_wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return ~(a | b);
      default: return b;
    endcase
  endfunction

  // One clock: check o_stall mid-cycle, then check EX/MEM after the edge
  task automatic cycle();
    logic [31:0] a, breg, bop, n_res, n_wd;
    logic [4:0]  ctl, dst, n_reg, n_ctl;
    logic        st, n_bub, n_zero;
    @(negedge clk);
    a    = fwd(i_rs, i_data1);
    breg = fwd(i_rt, i_data2);
    bop  = i_ALUSrc ? i_imm : breg;
    ctl  = {i_MemRead, i_MemWrite, i_PCSrc, i_RegWrite, i_MemToReg};
    dst  = i_RegDst ? i_rd : i_rt;
    n_res = 32'd0; n_wd = 32'd0; n_reg = 5'd0; n_ctl = 5'd0; n_bub = 1'b1; n_zero = 1'b0; st = 1'b0;
    if (rst) begin
      pend = 1'b0; n_bub = 1'b0;
    end else if (pend) begin
      if (age < 33) begin
        st = !i_flush;
        if (i_flush) pend = 1'b0;
        else age++;
      end else begin
        pend = 1'b0;
        if (!i_flush) begin
          n_res = p_prod; n_wd = p_b; n_reg = p_dest; n_ctl = p_ctl; n_bub = 1'b0; n_zero = (p_prod == 32'd0);
        end
      end
    end else if (i_ALUop == 3'd5 && !i_flush) begin
      st = 1'b1; pend = 1'b1; age = 1;
      p_prod = a * bop; p_b = breg; p_dest = dst; p_ctl = ctl;
    end else if (!i_flush) begin
      n_res = ref_alu(i_ALUop, a, bop); n_wd = breg; n_reg = dst; n_ctl = ctl; n_bub = 1'b0;
      n_zero = (n_res == 32'd0);
    end
    seen_stall = o_stall;
    chk("stall", {31'd0, o_stall}, {31'd0, st});
    @(posedge clk);
    #1;
    m_res = n_res; m_wd = n_wd; m_reg = n_reg; m_ctl = n_ctl; m_bub = n_bub; m_zero = n_zero;
    chk("ctrl", {27'd0, o_MemRead, o_MemWrite, o_PCSrc, o_RegWrite, o_MemToReg}, {27'd0, m_ctl});
    if (!m_bub) begin
      chk("alures", o_ALUres, m_res);
      chk("wdata", o_wdata, m_wd);
      chk("wreg", {27'd0, o_wreg}, {27'd0, m_reg});
      chk("zero", {31'd0, o_zero}, {31'd0, m_zero});
    end
  endtask

  task automatic clear_in();
    i_ALUSrc = 1'b0; i_ALUop = 3'd0; i_RegDst = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
    i_PCSrc = 1'b0; i_RegWrite = 1'b0; i_MemToReg = 1'b0; i_data1 = 32'd0; i_data2 = 32'd0;
    i_imm = 32'd0; i_rs = 5'd0; i_rt = 5'd0; i_rd = 5'd0; i_flush = 1'b0;
    i_wb_RegWrite = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'd0;
  endtask

  task automatic rtype(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    i_ALUop = op; i_rs = rs; i_rt = rt; i_rd = rd; i_data1 = d1; i_data2 = d2;
    i_RegDst = 1'b1; i_RegWrite = 1'b1; i_ALUSrc = 1'b0;
  endtask

  task automatic randomize_inputs();
    i_ALUSrc = 1'($urandom); i_RegDst = 1'($urandom);
    i_ALUop  = ($urandom_range(0, 7) == 0) ? 3'd5 : 3'($urandom);
    if (i_ALUop == 3'd5 && $urandom_range(0, 1) == 0) i_ALUop = 3'd0;
    i_MemRead = 1'($urandom); i_MemWrite = 1'($urandom); i_PCSrc = 1'($urandom);
    i_RegWrite = 1'($urandom); i_MemToReg = 1'($urandom);
    i_data1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    i_data2 = $urandom; i_imm = $urandom;
    i_rs = 5'($urandom_range(0, 3)); i_rt = 5'($urandom_range(0, 3)); i_rd = 5'($urandom_range(0, 3));
    i_wb_RegWrite = 1'($urandom); i_wb_rd = 5'($urandom_range(0, 3)); i_wb_data = $urandom;
  endtask

  initial begin
    int n;
    // Reset with random inputs
    randomize_inputs();
    i_flush = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      randomize_inputs();
      i_flush = 1'($urandom);
    end
    chk("reset_alures", o_ALUres, 32'd0);
    rst = 1'b0;

    // add $3,$1,$2
    clear_in(); rtype(3'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    cycle();
    chk("add_res", o_ALUres, 32'd12);
    chk("add_wreg", {27'd0, o_wreg}, 32'd3);
    // sub $4,$3,$2 via EX/MEM forward
    rtype(3'd1, 5'd3, 5'd2, 5'd4, 32'd0, 32'd7);
    cycle();
    chk("fwd_exmem", o_ALUres, 32'd5);
    // WB-only forward
    i_wb_RegWrite = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'd20;
    rtype(3'd1, 5'd3, 5'd2, 5'd5, 32'd0, 32'd7);
    cycle();
    chk("fwd_wb", o_ALUres, 32'd13);
    // Both match: EX/MEM wins
    i_wb_RegWrite = 1'b0;
    rtype(3'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    cycle();
    i_wb_RegWrite = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'd20;
    rtype(3'd1, 5'd3, 5'd2, 5'd4, 32'd0, 32'd7);
    cycle();
    chk("fwd_priority", o_ALUres, 32'd5);
    // Register 0 never forwarded
    i_wb_RegWrite = 1'b0;
    rtype(3'd0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7);
    cycle();
    rtype(3'd1, 5'd0, 5'd2, 5'd4, 32'd0, 32'd7);
    cycle();
    chk("no_fwd_r0", o_ALUres, 32'hFFFF_FFF9);

    // mul 6x7 then mul 0xFFFFFFFF x 2, back to back
    clear_in(); rtype(3'd5, 5'd1, 5'd2, 5'd8, 32'd6, 32'd7);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (seen_stall) n++;
      else break;
    end
    chk("mul1_stall_cycles", n, 33);
    chk("mul1_res", o_ALUres, 32'd42);
    chk("mul1_regwrite", {31'd0, o_RegWrite}, 32'd1);
    rtype(3'd5, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (seen_stall) n++;
      else break;
    end
    chk("mul2_stall_cycles", n, 33);
    chk("mul2_res", o_ALUres, 32'hFFFF_FFFE);
    clear_in();
    cycle();
    chk("after_mul_regwrite", {31'd0, o_RegWrite}, 32'd0);

    // Flush during multiply
    rtype(3'd5, 5'd1, 5'd2, 5'd10, 32'd3, 32'd3);
    for (int k = 0; k < 10; k++) cycle();
    i_flush = 1'b1;
    cycle();
    chk("flush_stall", {31'd0, seen_stall}, 32'd0);
    chk("flush_regwrite", {31'd0, o_RegWrite}, 32'd0);
    clear_in(); rtype(3'd0, 5'd1, 5'd2, 5'd11, 32'd100, 32'd23);
    cycle();
    chk("after_flush_add", o_ALUres, 32'd123);
    clear_in();
    for (int k = 0; k < 40; k++) cycle();

    // Reset in the middle of a multiply
    rtype(3'd5, 5'd1, 5'd2, 5'd12, 32'd9, 32'd9);
    for (int k = 0; k < 5; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_res", o_ALUres, 32'd0);
    clear_in(); rtype(3'd4, 5'd1, 5'd2, 5'd13, 32'hFFFF_FFFF, 32'd1);
    cycle();
    chk("midrst_stall", {31'd0, seen_stall}, 32'd0);
    chk("slt", o_ALUres, 32'd1);
    // sw: base + 8, store data forwarded from WB
    clear_in();
    i_ALUSrc = 1'b1; i_imm = 32'd8; i_ALUop = 3'd0; i_MemWrite = 1'b1;
    i_rs = 5'd5; i_rt = 5'd6; i_data1 = 32'h100; i_data2 = 32'h5555;
    i_wb_RegWrite = 1'b1; i_wb_rd = 5'd6; i_wb_data = 32'hABCD;
    cycle();
    chk("sw_addr", o_ALUres, 32'h108);
    chk("sw_wdata", o_wdata, 32'hABCD);

    // Random traffic; ID/EX is frozen while the stage stalls
    clear_in();
    randomize_inputs();
    for (int k = 0; k < 1500; k++) begin
      cycle();
      rst     = ($urandom_range(0, 199) == 0);
      i_flush = ($urandom_range(0, 29) == 0);
      if (!seen_stall) randomize_inputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
